// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed scan of NUM_DIGITS BCD digits onto one
// shared decoder. New digit words land in a shadow register and are copied
// to the display register only at a frame boundary (or while idle), so one
// frame never mixes old and new digits.
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              BCD,
  output logic                    bcd_valid,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    err_invalid
);

  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] PS_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]   disp, shadow;
  logic                         pending;
  logic                         accept, commit, frame_end, bad_nibble;

  // load_ready is the registered inverse of the pending flag
  assign pending = ~load_ready;
  assign accept  = load_valid & load_ready;
  // frame_end only fires on the last SHOW cycle of the last digit with enable high
  assign commit  = pending & ((state == IDLE) | frame_end);

  // flag any non-decimal nibble in the incoming word
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (load_data[4*i +: 4] > 4'd9) bad_nibble = 1'b1;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // next-state: blank gap, then show window, advance digit; enable low forces idle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_end = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          if (cnt == BL_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == PS_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
              idx_nxt   = '0;
              frame_end = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // digit storage and handshake; accept and commit are exclusive via pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp        <= {NUM_DIGITS{4'hF}};
      shadow      <= {NUM_DIGITS{4'hF}};
      load_ready  <= 1'b1;
      err_invalid <= 1'b0;
    end else begin
      err_invalid <= accept & bad_nibble;
      if (accept) begin
        shadow     <= load_data;
        load_ready <= 1'b0;
      end else if (commit) begin
        disp       <= shadow;
        load_ready <= 1'b1;
      end
    end
  end

  // registered outputs follow the current state one cycle later; enable low blanks at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BCD        <= 4'hF;
      bcd_valid  <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      BCD        <= 4'hF;
      bcd_valid  <= 1'b0;
      digit_sel  <= '0;
      frame_done <= frame_end;
      if (enable && state == SHOW) begin
        BCD       <= disp[idx];
        bcd_valid <= (disp[idx] <= 4'd9);
        digit_sel <= NUM_DIGITS'(1) << idx;
      end
    end
  end

endmodule
